// File: rtl/pixel_array_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_array_sequencer_if
// Purpose  : Control/status bundle between the system controller (master) and
//            the pixel array frame sequencer (slave).
// Options  : PIXSEQ_EXPOSE_PROG_EN adds the runtime expose_len field.
// Revision : 1.0  initial release
// ============================================================================
interface pixel_array_sequencer_if #(
  parameter int BIT_DEPTH = 8
`ifdef PIXSEQ_EXPOSE_PROG_EN
  , parameter int CNT_W   = 16
`endif
);
  logic                 start;
  logic                 abort;
  logic                 continuous;
`ifdef PIXSEQ_EXPOSE_PROG_EN
  logic [CNT_W-1:0]     expose_len;
`endif
  logic                 busy;
  logic                 frame_done;
  logic                 power_enable;
  logic                 erase;
  logic                 expose;
  logic                 convert;
  logic                 write_enable;
  logic                 counter_reset;
  logic                 read;
  logic [BIT_DEPTH-1:0] ramp_code;

  modport master (
`ifdef PIXSEQ_EXPOSE_PROG_EN
    output expose_len,
`endif
    output start, abort, continuous,
    input  busy, frame_done, power_enable, erase, expose, convert,
           write_enable, counter_reset, read, ramp_code
  );

  modport slave (
`ifdef PIXSEQ_EXPOSE_PROG_EN
    input  expose_len,
`endif
    input  start, abort, continuous,
    output busy, frame_done, power_enable, erase, expose, convert,
           write_enable, counter_reset, read, ramp_code
  );
endinterface
`default_nettype wire

// File: rtl/pixel_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_array_sequencer
// Purpose  : One frame per request: ERASE -> EXPOSE -> CONVERT -> READ, with
//            registered pixel strobes and a saturating ramp code.
// Options  : PIXSEQ_EXPOSE_PROG_EN selects a runtime exposure length.
// Revision : 1.0  initial release
// ============================================================================
module pixel_array_sequencer #(
  parameter int CNT_W     = 16,
  parameter int BIT_DEPTH = 8,
  parameter int C_ERASE   = 5,
  parameter int C_EXPOSE  = 255,
  parameter int C_CONVERT = 255,
  parameter int C_READ    = 5
) (
  input  wire logic               clk,
  input  wire logic               reset,
  pixel_array_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]     LEN_ERASE   = CNT_W'(C_ERASE);
  localparam logic [CNT_W-1:0]     LEN_EXPOSE  = CNT_W'(C_EXPOSE);
  localparam logic [CNT_W-1:0]     LEN_CONVERT = CNT_W'(C_CONVERT);
  localparam logic [CNT_W-1:0]     LEN_READ    = CNT_W'(C_READ);
  localparam logic [BIT_DEPTH-1:0] RAMP_MAX    = {BIT_DEPTH{1'b1}};

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     phase_len;
  logic                 phase_last;
  logic [CNT_W-1:0]     expose_len_cur;
  logic                 erase_entry;

  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 power_enable_q, power_enable_d;
  logic                 erase_q, erase_d;
  logic                 expose_q, expose_d;
  logic                 convert_q, convert_d;
  logic                 write_enable_q, write_enable_d;
  logic                 counter_reset_q, counter_reset_d;
  logic                 read_q, read_d;
  logic [BIT_DEPTH-1:0] ramp_q, ramp_d;

  assign erase_entry = (state_d == S_ERASE) && (state_q != S_ERASE);

`ifdef PIXSEQ_EXPOSE_PROG_EN
  // Latched at every ERASE entry so a mid-frame change only affects later frames.
  logic [CNT_W-1:0] expose_len_q, expose_len_d;

  always_comb begin
    expose_len_d = expose_len_q;
    if (erase_entry) begin
      expose_len_d = (bus.expose_len == '0) ? CNT_W'(1) : bus.expose_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expose_len_q <= LEN_EXPOSE;
    end else begin
      expose_len_q <= expose_len_d;
    end
  end

  assign expose_len_cur = expose_len_q;
`else
  assign expose_len_cur = LEN_EXPOSE;
`endif

  always_comb begin
    phase_len = CNT_W'(1);
    case (state_q)
      S_ERASE:   phase_len = LEN_ERASE;
      S_EXPOSE:  phase_len = expose_len_cur;
      S_CONVERT: phase_len = LEN_CONVERT;
      S_READ:    phase_len = LEN_READ;
      default:   phase_len = CNT_W'(1);
    endcase
  end

  assign phase_last = (cnt_q == (phase_len - CNT_W'(1)));

  // Next state; abort overrides every other transition and suppresses frame_done.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_ERASE;
      end
      S_ERASE: begin
        if (phase_last) state_d = S_EXPOSE;
      end
      S_EXPOSE: begin
        if (phase_last) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        if (phase_last) state_d = S_READ;
      end
      S_READ: begin
        if (phase_last) begin
          frame_done_d = 1'b1;
          state_d      = bus.continuous ? S_ERASE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) begin
      state_d      = S_IDLE;
      frame_done_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      cnt_d = '0;
    end
  end

  // Strobes are decoded from the next state so they flip on the same edge as the state.
  always_comb begin
    busy_d          = (state_d != S_IDLE);
    erase_d         = (state_d == S_ERASE);
    expose_d        = (state_d == S_EXPOSE);
    convert_d       = (state_d == S_CONVERT);
    read_d          = (state_d == S_READ);
    power_enable_d  = expose_d || convert_d || read_d;
    write_enable_d  = expose_d || convert_d;
    counter_reset_d = (state_q == S_CONVERT) && (state_d == S_READ);
    ramp_d          = '0;
    if ((state_q == S_CONVERT) && (state_d == S_CONVERT)) begin
      ramp_d = (ramp_q == RAMP_MAX) ? ramp_q : (ramp_q + BIT_DEPTH'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      power_enable_q  <= 1'b0;
      erase_q         <= 1'b0;
      expose_q        <= 1'b0;
      convert_q       <= 1'b0;
      write_enable_q  <= 1'b0;
      counter_reset_q <= 1'b0;
      read_q          <= 1'b0;
      ramp_q          <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      power_enable_q  <= power_enable_d;
      erase_q         <= erase_d;
      expose_q        <= expose_d;
      convert_q       <= convert_d;
      write_enable_q  <= write_enable_d;
      counter_reset_q <= counter_reset_d;
      read_q          <= read_d;
      ramp_q          <= ramp_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.power_enable  = power_enable_q;
  assign bus.erase         = erase_q;
  assign bus.expose        = expose_q;
  assign bus.convert       = convert_q;
  assign bus.write_enable  = write_enable_q;
  assign bus.counter_reset = counter_reset_q;
  assign bus.read          = read_q;
  assign bus.ramp_code     = ramp_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pixel_array_sequencer
// Purpose  : Scoreboard bench; expected frame records are queued at start and
//            compared by a monitor at each frame_done. PIXSEQ_EXPOSE_PROG_EN aware.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_array_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_array_sequencer_if #(.BIT_DEPTH(8)) bus ();
  pixel_array_sequencer_if #(.BIT_DEPTH(8)) sbus ();

  pixel_array_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pixel_array_sequencer #(
    .C_ERASE   (1),
    .C_EXPOSE  (1),
    .C_CONVERT (300),
    .C_READ    (1)
  ) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  typedef struct {
    int   done_cyc;
    int   n_erase;
    int   n_expose;
    int   n_convert;
    int   n_read;
    int   n_cr;
    int   n_busy;
    int   n_pe;
    int   n_we;
    int   ramp_max;
    logic busy_after;
  } frame_t;

  frame_t exp_q[$];
  int     ramp_exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int outs_main();
    return {bus.busy, bus.frame_done, bus.power_enable, bus.erase, bus.expose,
            bus.convert, bus.write_enable, bus.counter_reset, bus.read, bus.ramp_code};
  endfunction

  task automatic push_frame(input int done_cyc, input int n_exp, input logic busy_after);
    frame_t f;
    f.done_cyc   = done_cyc;
    f.n_erase    = 5;
    f.n_expose   = n_exp;
    f.n_convert  = 255;
    f.n_read     = 5;
    f.n_cr       = 1;
    f.n_busy     = 5 + n_exp + 255 + 5;
    f.n_pe       = n_exp + 255 + 5;
    f.n_we       = n_exp + 255;
    f.ramp_max   = 254;
    f.busy_after = busy_after;
    exp_q.push_back(f);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Main monitor: per-frame tallies, compared against the queued record at frame_done.
  initial begin
    frame_t a;
    frame_t e;
    int     ramp_bad;
    a = '{default: 0};
    ramp_bad = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        a = '{default: 0};
        ramp_bad = 0;
      end else begin
        if (bus.frame_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle",     cyc,         e.done_cyc);
            check("erase_cycles",   a.n_erase,   e.n_erase);
            check("expose_cycles",  a.n_expose,  e.n_expose);
            check("convert_cycles", a.n_convert, e.n_convert);
            check("read_cycles",    a.n_read,    e.n_read);
            check("counter_reset",  a.n_cr,      e.n_cr);
            check("busy_cycles",    a.n_busy,    e.n_busy);
            check("power_en_cycles",a.n_pe,      e.n_pe);
            check("write_en_cycles",a.n_we,      e.n_we);
            check("ramp_max",       a.ramp_max,  e.ramp_max);
            check("ramp_outside",   ramp_bad,    0);
            check("busy_at_done",   int'(bus.busy), int'(e.busy_after));
          end
          a = '{default: 0};
          ramp_bad = 0;
        end else if (!bus.busy) begin
          a = '{default: 0};
          ramp_bad = 0;
        end
        a.n_erase   += int'(bus.erase);
        a.n_expose  += int'(bus.expose);
        a.n_convert += int'(bus.convert);
        a.n_read    += int'(bus.read);
        a.n_cr      += int'(bus.counter_reset);
        a.n_busy    += int'(bus.busy);
        a.n_pe      += int'(bus.power_enable);
        a.n_we      += int'(bus.write_enable);
        if (int'(bus.ramp_code) > a.ramp_max) a.ramp_max = int'(bus.ramp_code);
        if (!bus.convert && bus.ramp_code != 8'd0) ramp_bad++;
      end
    end
  end

  // Saturation monitor: every CONVERT cycle of the long-convert instance pops one value.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && sbus.convert) begin
        if (ramp_exp_q.size() == 0) check("sat_unexpected_convert", 1, 0);
        else check("sat_ramp", int'(sbus.ramp_code), ramp_exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.continuous  = 1'b0;
    sbus.start      = 1'b0;
    sbus.abort      = 1'b0;
    sbus.continuous = 1'b0;
`ifdef PIXSEQ_EXPOSE_PROG_EN
    bus.expose_len  = 16'd255;
    sbus.expose_len = 16'd1;
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_main(), 0);
    check("reset_sat_outputs", int'({sbus.busy, sbus.erase, sbus.ramp_code}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", int'(bus.busy), 0);

    // Long CONVERT: ramp 0..255 then held at 255, 300 cycles in total.
    for (int i = 0; i < 300; i++) ramp_exp_q.push_back((i > 255) ? 255 : i);
    sbus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    sbus.start = 1'b0;
    wait_cyc(s + 303);
    check("sat_frame_done", int'(sbus.frame_done), 1);
    check("sat_ramp_after_exit", int'(sbus.ramp_code), 0);
    check("sat_ramp_all_seen", ramp_exp_q.size(), 0);

    // Single frame; a mid-frame start must not queue a second frame.
    bus.start = 1'b1;
    s = cyc + 1;
    push_frame(s + 520, 255, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("start_latency_erase", int'({bus.busy, bus.erase}), 3);
    wait_cyc(s + 100);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(s + 530);
    check("idle_after_frame", int'(bus.busy), 0);

    // abort together with start in IDLE keeps the sequencer idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_idle", outs_main(), 0);

    // Abort on EXPOSE cycle 10, then restart on the very next cycle.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.expose && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_expose", int'(bus.expose), 1);
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_outputs", outs_main(), 0);
    bus.start = 1'b1;
    s = cyc + 1;
    push_frame(s + 520, 255, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_after_abort", int'({bus.busy, bus.erase}), 3);
    wait_cyc(s + 525);

    // Continuous: three back-to-back frames, continuous dropped during the third.
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    s = cyc + 1;
    push_frame(s + 520,  255, 1'b1);
    push_frame(s + 1040, 255, 1'b1);
    push_frame(s + 1560, 255, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(s + 1200);
    bus.continuous = 1'b0;
    wait_cyc(s + 1565);
    check("idle_after_continuous", int'(bus.busy), 0);

    // Asynchronous reset in the middle of CONVERT.
    bus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(s + 300);
    check("in_convert_before_reset", int'(bus.convert), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", outs_main(), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_async_reset", int'(bus.busy), 0);
    bus.start = 1'b1;
    s = cyc + 1;
    push_frame(s + 520, 255, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(s + 525);

`ifdef PIXSEQ_EXPOSE_PROG_EN
    // Runtime exposure: 3 cycles with a mid-frame change ignored, then 0 treated as 1.
    bus.expose_len = 16'd3;
    bus.start = 1'b1;
    s = cyc + 1;
    push_frame(s + 268, 3, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.expose_len = 16'd9;
    wait_cyc(s + 272);
    bus.expose_len = 16'd0;
    bus.start = 1'b1;
    s = cyc + 1;
    push_frame(s + 266, 1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(s + 270);
    bus.expose_len = 16'd255;
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
